// File: rtl/div_pkg.sv
// Shared types and constants for the 8-bit restoring divider.
package div_pkg;

    localparam int WIDTH = 8;

    // Quotient reported when the divisor is zero.
    localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/restoring_div_8b_if.sv
// Request/result bundle between a divider client and restoring_div_8b.
interface restoring_div_8b_if;
    import div_pkg::*;

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/sub8.sv
// 8-bit ripple-borrow subtractor: diff = a - b - bin, bout set on underflow.
module sub8
    import div_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    logic [WIDTH:0] borrow;

    // Full-subtractor chain, LSB to MSB.
    always_comb begin
        borrow    = '0;
        diff      = '0;
        borrow[0] = bin;
        for (int i = 0; i < WIDTH; i++) begin
            diff[i]       = a[i] ^ b[i] ^ borrow[i];
            borrow[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
        end
        bout = borrow[WIDTH];
    end

endmodule

// File: rtl/restoring_div_8b.sv
// Sequential 8-bit unsigned restoring divider: one quotient bit per RUN cycle,
// using sub8 to trial-subtract the divisor from the shifted partial remainder.
module restoring_div_8b
    import div_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    restoring_div_8b_if.slave    bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    // Partial remainder is at most 127 between iterations, so only 7 bits are
    // kept; the full 8-bit remainder of the last iteration goes to rem_q.
    logic [WIDTH-2:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ok;

    assign p  = {r_q, q_q[WIDTH-1]};
    assign ok = ~bout;

    sub8 u_sub8 (
        .a    (p),
        .b    (d_q),
        .bin  (1'b0),
        .diff (diff),
        .bout (bout)
    );

    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dz_q;

    // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = {1'b0, r_q};
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    if (bus.divisor != '0) begin
                        q_d     = bus.dividend;
                        r_d     = '0;
                        d_d     = bus.divisor;
                        cnt_d   = 3'd0;
                        dz_d    = 1'b0;
                        state_d = RUN;
                    end else begin
                        quot_d  = DIV0_QUOTIENT;
                        rem_d   = bus.dividend;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                r_d   = ok ? diff : p;
                q_d   = {q_q[WIDTH-2:0], ok};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    quot_d  = q_d;
                    rem_d   = r_d;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and result registers, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    // Iteration operands; always reloaded on an accepted start, so no reset.
    always_ff @(posedge clk) begin
        q_q <= q_d;
        r_q <= r_d[WIDTH-2:0];
        d_q <= d_d;
    end

endmodule
